// File: rtl/fp_norm_round_if.sv
// Handshake and data bundle between the add/sub datapath, the normalize/round
// stage and the FPU result mux.
interface fp_norm_round_if;
  // Upstream beat: unnormalized add/sub result
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp;
  logic [48:0] in_man;

  // Downstream beat: packed single-precision result plus status
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  // Producer side: drives the input beat and accepts the result
  modport master (
    output in_valid,
    output in_sign,
    output in_exp,
    output in_man,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_overflow,
    input  out_underflow,
    input  out_inexact,
    output out_ready
  );

  // Normalize/round stage side
  modport slave (
    input  in_valid,
    input  in_sign,
    input  in_exp,
    input  in_man,
    output in_ready,
    output out_valid,
    output out_result,
    output out_overflow,
    output out_underflow,
    output out_inexact,
    input  out_ready
  );
endinterface

// File: rtl/fp_norm_round.sv
// Three-stage normalize + round-to-nearest-even + pack for the FPU add/sub
// result. S1 captures the beat and counts leading zeros, S2 shifts and fixes
// the exponent, S3 rounds, packs and registers the outputs. The whole pipe
// advances together whenever the output is empty or being accepted.
module fp_norm_round (
  input  logic           clk,
  input  logic           rst_n,
  fp_norm_round_if.slave bus
);

  // Leading-zero count of a 48-bit vector; the highest set bit wins.
  function automatic logic [5:0] lzc48(input logic [47:0] v);
    logic [5:0] n;
    n = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (v[i]) begin
        n = 6'(47 - i);
      end
    end
    return n;
  endfunction

  logic advance;

  // ---------------------------------------------------------------------------
  // S1: capture + leading-zero count
  // ---------------------------------------------------------------------------
  logic        s1_valid_q;
  logic        s1_sign_q;
  logic [9:0]  s1_exp_q;   // effective exponent E = max(in_exp, 1)
  logic [48:0] s1_man_q;
  logic        s1_zero_q;
  logic [5:0]  s1_lz_q;

  logic [9:0]  s1_exp_d;
  logic [5:0]  s1_lz_d;

  // Denormal inputs share the scale of exponent 1.
  always_comb begin
    s1_exp_d = (bus.in_exp == 9'd0) ? 10'd1 : {1'b0, bus.in_exp};
    s1_lz_d  = lzc48(bus.in_man[47:0]);
  end

  // S1 registers load on advance; bubbles shift through like real beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_lz_q    <= '0;
    end else if (advance) begin
      s1_valid_q <= bus.in_valid;
      s1_sign_q  <= bus.in_sign;
      s1_exp_q   <= s1_exp_d;
      s1_man_q   <= bus.in_man;
      s1_zero_q  <= (bus.in_man == 49'd0);
      s1_lz_q    <= s1_lz_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: normalizing shift + exponent adjust
  // ---------------------------------------------------------------------------
  logic        s2_valid_q;
  logic        s2_sign_q;
  logic [9:0]  s2_exp_q;   // exponent field before rounding (0 = denormal)
  logic [46:0] s2_man_q;   // hidden bit dropped; implied by s2_exp_q != 0
  logic        s2_sticky_q;
  logic        s2_zero_q;

  logic [9:0]  exp_m1;
  logic [5:0]  sh;
  logic [47:0] man_shl;
  logic [47:0] s2_man_d;
  logic [9:0]  s2_exp_d;
  logic        s2_sticky_d;

  // Carry-out shifts right by one; otherwise shift left, but never past the
  // denormal scale so the exponent bottoms out at 1.
  always_comb begin
    exp_m1 = s1_exp_q - 10'd1;
    if ({4'd0, s1_lz_q} > exp_m1) begin
      sh = exp_m1[5:0];
    end else begin
      sh = s1_lz_q;
    end
    man_shl = s1_man_q[47:0] << sh;

    if (s1_man_q[48]) begin
      s2_man_d    = s1_man_q[48:1];
      s2_sticky_d = s1_man_q[0];
      s2_exp_d    = s1_exp_q + 10'd1;
    end else begin
      s2_man_d    = man_shl;
      s2_sticky_d = 1'b0;
      s2_exp_d    = s1_exp_q - {4'd0, sh};
    end

    // Hidden bit still clear after the limited shift: denormal result.
    if (!s2_man_d[47]) begin
      s2_exp_d = 10'd0;
    end
  end

  // S2 registers load on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_man_q    <= '0;
      s2_sticky_q <= 1'b0;
      s2_zero_q   <= 1'b0;
    end else if (advance) begin
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_exp_q    <= s2_exp_d;
      s2_man_q    <= s2_man_d[46:0];
      s2_sticky_q <= s2_sticky_d;
      s2_zero_q   <= s1_zero_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: round-to-nearest-even + pack
  // ---------------------------------------------------------------------------
  logic        out_valid_q;
  logic [31:0] out_result_q;
  logic        out_overflow_q;
  logic        out_underflow_q;
  logic        out_inexact_q;

  logic [22:0] frac;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] frac_sum;
  logic [9:0]  exp_r;
  logic        ovf;
  logic        inexact;
  logic [31:0] result_d;
  logic        overflow_d;
  logic        underflow_d;
  logic        inexact_d;

  // A fraction carry bumps the exponent; for a denormal (field 0) that lands
  // exactly on the minimum normal with a zero fraction.
  always_comb begin
    frac     = s2_man_q[46:24];
    guard    = s2_man_q[23];
    sticky   = (|s2_man_q[22:0]) | s2_sticky_q;
    round_up = guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {23'd0, round_up};
    exp_r    = s2_exp_q + {9'd0, frac_sum[23]};
    ovf      = (exp_r >= 10'd255);
    inexact  = guard | sticky;

    if (s2_zero_q) begin
      result_d    = 32'h0000_0000;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      inexact_d   = 1'b0;
    end else if (ovf) begin
      result_d    = {s2_sign_q, 8'hFF, 23'd0};
      overflow_d  = 1'b1;
      underflow_d = inexact & (s2_exp_q == 10'd0);
      inexact_d   = inexact;
    end else begin
      result_d    = {s2_sign_q, exp_r[7:0], frac_sum[22:0]};
      overflow_d  = 1'b0;
      underflow_d = inexact & (s2_exp_q == 10'd0);
      inexact_d   = inexact;
    end
  end

  // Output registers load on advance and otherwise hold the presented beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_overflow_q  <= 1'b0;
      out_underflow_q <= 1'b0;
      out_inexact_q   <= 1'b0;
    end else if (advance) begin
      out_valid_q     <= s2_valid_q;
      out_result_q    <= result_d;
      out_overflow_q  <= overflow_d;
      out_underflow_q <= underflow_d;
      out_inexact_q   <= inexact_d;
    end
  end

  // Global stall: the pipe moves only when the output slot frees up.
  always_comb begin
    advance           = ~out_valid_q | bus.out_ready;
    bus.in_ready      = advance;
    bus.out_valid     = out_valid_q;
    bus.out_result    = out_result_q;
    bus.out_overflow  = out_overflow_q;
    bus.out_underflow = out_underflow_q;
    bus.out_inexact   = out_inexact_q;
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed vectors with hand-computed results feed a
// scoreboard queue; an independent monitor pops and compares on every output
// handshake, and also checks stall behaviour.
module tb_fp_norm_round;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        uf;
    logic        inx;
  } exp_t;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [48:0] man;
    exp_t        want;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb[$];
  vec_t vecs[$];

  fp_norm_round_if bus ();

  fp_norm_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic [8:0] e, input logic [48:0] m,
                              input logic [31:0] r, input logic o, input logic u,
                              input logic x);
    vec_t v;
    v.sign = s;
    v.exp  = e;
    v.man  = m;
    v.want = '{res: r, ovf: o, uf: u, inx: x};
    return v;
  endfunction

  task automatic fail_msg(input string name, input logic [63:0] got, input logic [63:0] want);
    fails++;
    $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Present one beat; the expectation is queued when the handshake is certain.
  task automatic send(input vec_t v);
    int n;
    bus.in_valid = 1'b1;
    bus.in_sign  = v.sign;
    bus.in_exp   = v.exp;
    bus.in_man   = v.man;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(v.want);
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 100) begin
        tests++;
        fail_msg("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fail_msg("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard compare on handshake, hold/in_ready checks on stall.
  initial begin : monitor
    exp_t        e;
    exp_t        got;
    logic [31:0] held;
    logic        held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
        continue;
      end
      if (bus.out_valid && !bus.out_ready) begin
        tests++;
        if (bus.in_ready !== 1'b0) fail_msg("stall_in_ready", 64'(bus.in_ready), 64'd0);
        if (held_v) begin
          tests++;
          if (bus.out_result !== held) fail_msg("stall_hold", 64'(bus.out_result), 64'(held));
        end
        held   = bus.out_result;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        got = '{res: bus.out_result, ovf: bus.out_overflow, uf: bus.out_underflow,
                inx: bus.out_inexact};
        if (sb.size() == 0) begin
          fail_msg("unexpected_out", 64'(got), 64'd0);
        end else begin
          e = sb.pop_front();
          if (got !== e) fail_msg("result", 64'(got), 64'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   n;
    logic seen;
    tests = 0;
    fails = 0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_man    = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;

    vecs.push_back(mk(1'b0, 9'd127, 49'h1_0000_0000_0000, 32'h4000_0000, 0, 0, 0));
    vecs.push_back(mk(1'b0, 9'd127, 49'h0_2000_0000_0000, 32'h3E80_0000, 0, 0, 0));
    vecs.push_back(mk(1'b0, 9'd127, 49'h0_8000_0080_0000, 32'h3F80_0000, 0, 0, 1));
    vecs.push_back(mk(1'b0, 9'd127, 49'h0_8000_0180_0000, 32'h3F80_0002, 0, 0, 1));
    vecs.push_back(mk(1'b0, 9'd254, 49'h1_0000_0000_0000, 32'h7F80_0000, 1, 0, 0));
    vecs.push_back(mk(1'b0, 9'd1,   49'h0_4000_0000_0000, 32'h0040_0000, 0, 0, 0));
    vecs.push_back(mk(1'b1, 9'd100, 49'h0_0000_0000_0000, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(1'b1, 9'd127, 49'h0_8000_0000_0001, 32'hBF80_0000, 0, 0, 1));
    vecs.push_back(mk(1'b0, 9'd127, 49'h1_0000_0000_0001, 32'h4000_0000, 0, 0, 1));
    vecs.push_back(mk(1'b0, 9'd0,   49'h0_0000_0180_0000, 32'h0000_0002, 0, 1, 1));
    vecs.push_back(mk(1'b0, 9'd1,   49'h0_7FFF_FF80_0000, 32'h0080_0000, 0, 1, 1));
    vecs.push_back(mk(1'b0, 9'd254, 49'h0_FFFF_FF80_0000, 32'h7F80_0000, 1, 0, 1));
    vecs.push_back(mk(1'b0, 9'd3,   49'h0_1000_0000_0000, 32'h0040_0000, 0, 0, 0));
    vecs.push_back(mk(1'b0, 9'd0,   49'h0_8000_0000_0000, 32'h0080_0000, 0, 0, 0));
    vecs.push_back(mk(1'b0, 9'd127, 49'h0_0000_0000_0001, 32'h2800_0000, 0, 0, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.out_valid, bus.out_result, bus.out_overflow, bus.out_underflow,
         bus.out_inexact} !== 36'd0)
      fail_msg("reset_outputs", 64'({bus.out_valid, bus.out_result}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) fail_msg("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Latency of a lone beat
    send(vecs[0]);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = bus.out_valid;
    end
    tests++;
    if (n != 3) fail_msg("latency", 64'(n), 64'd3);
    drain();

    // All directed vectors back to back
    foreach (vecs[i]) send(vecs[i]);
    drain();

    // Backpressure: 4 beats, out_ready low during cycles 2..4
    fork
      begin
        for (int i = 0; i < 4; i++) send(vecs[i + 2]);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i]);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.out_valid, bus.out_result} !== 33'd0)
      fail_msg("async_reset_drop", 64'({bus.out_valid, bus.out_result}), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) fail_msg("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    tests++;
    if (seen) fail_msg("post_reset_quiet", 64'(seen), 64'd0);
    send(vecs[3]);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
